// File: rtl/regfile_dbg_pkg.sv
// Shared constants and types for the RegFile debug read-out path.
//   ADDR_W       : register address width (32 architectural registers)
//   DATA_W       : register data width
//   dump_state_e : state encoding of the regfile_dumper controller
package regfile_dbg_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_READ,
        ST_SEND,
        ST_DONE
    } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Debug read-out engine for the RegFile. On a start request it asks the
// pipeline to hold register writes, then walks the inclusive range
// first..last through one asynchronous read port. Each value is streamed
// to the debug link with its register index over a valid/ready handshake.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle dump request, honoured only when idle
//   first/last : inclusive register range, latched with start
//   hold_req   : ask the pipeline to stall register writes
//   hold_ack   : pipeline has stalled (looked at only while waiting for it)
//   ra / rd    : RegFile read address / combinational read data
//   out_valid  : beat presented on out_data/out_addr
//   out_ready  : debug link accepts the beat
//   out_data   : register value of the current beat
//   out_addr   : register index of the current beat
//   busy       : dump in progress (any state but idle)
//   done       : one-cycle pulse after the final beat is accepted
//   range_err  : one-cycle pulse when start arrives with first > last
//
// State      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start; hold released
// ST_WAIT_ACK| hold_req raised, waiting for the pipeline to stall
// ST_READ    | ra = addr; rd captured into the output register at the edge
// ST_SEND    | beat presented, waiting for out_ready
// ST_DONE    | final beat accepted; done high, hold drops on the way out
module regfile_dumper
    import regfile_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    dump_state_e       state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic              hold_req_q,  hold_req_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              range_err_q, range_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            hold_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            hold_req_q  <= hold_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        hold_req_d  = hold_req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;
        range_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first <= last) begin
                        addr_d     = first;
                        last_d     = last;
                        hold_req_d = 1'b1;
                        state_d    = ST_WAIT_ACK;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end

            ST_WAIT_ACK: begin
                if (hold_ack) begin
                    state_d = ST_READ;
                end
            end

            // ra has been driven from addr_q for the whole cycle, so rd
            // has settled by this edge.
            ST_READ: begin
                out_data_d  = rd;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end

            // Comparing against last before incrementing keeps addr from
            // ever stepping past last, so last = 31 cannot wrap to 0.
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                hold_req_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                hold_req_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Registered busy follows the state being entered, so it falls on
        // the same edge that ends the done pulse.
        busy_d = (state_d != ST_IDLE);
    end

    assign hold_req  = hold_req_q;
    assign ra        = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_regfile_dumper.sv
module tb_regfile_dumper;
    import regfile_dbg_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    logic              hold_req;
    logic              hold_ack;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    logic              range_err;

    logic [DATA_W-1:0] regs [32];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    regfile_dumper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first     (first),
        .last      (last),
        .hold_req  (hold_req),
        .hold_ack  (hold_ack),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    // Behavioural RegFile read port: combinational.
    assign rd = regs[ra];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Runs one dump and compares every accepted beat against the list of
    // (index, value) pairs the range should produce. span returns edges
    // from the ack edge to the edge that raises done (-1 if none).
    task automatic do_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int ack_dly, input int stall_beat, input int stall_len,
                           input bit rnd, output int span);
        logic [ADDR_W-1:0] qa[$];
        logic [DATA_W-1:0] qd[$];
        int i = 0;
        int beat = 0;
        int stall_left;
        int ack_cyc = -1;
        int budget = 400;
        bit done_seen = 0;
        bit held = 0;
        logic [DATA_W-1:0] pd = '0;
        logic [ADDR_W-1:0] pa = '0;
        stall_left = stall_len;
        span = -1;
        for (int a = int'(f); a <= int'(l); a++) begin
            qa.push_back(ADDR_W'(a));
            qd.push_back(regs[a]);
        end
        start = 1'b1; first = f; last = l; out_ready = 1'b0; hold_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hold_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_hold: hold_req=%b busy=%b, want 1 1", hold_req, busy);
        end
        while (!done_seen && budget > 0) begin
            checks++;
            if (range_err !== 1'b0) begin
                errors++;
                $display("FAIL range_err_busy: range_err=%b while busy, want 0", range_err);
            end
            if (out_valid === 1'b1) begin
                if (held) begin
                    checks++;
                    if (out_data !== pd || out_addr !== pa) begin
                        errors++;
                        $display("FAIL beat_stable: got (%0d,%h), want (%0d,%h)", out_addr, out_data, pa, pd);
                    end
                end
            end else if (qa.size() > 0) begin
                checks++;
                if (ra !== qa[0]) begin
                    errors++;
                    $display("FAIL ra_addr: ra=%0d, want %0d", ra, qa[0]);
                end
            end
            if (done === 1'b1) begin
                done_seen = 1;
                span = cyc - ack_cyc;
                start = 1'b0; hold_ack = 1'b0; out_ready = 1'b0;
                checks++;
                if (qa.size() != 0 || busy !== 1'b1 || hold_req !== 1'b1) begin
                    errors++;
                    $display("FAIL done_state: beats_left=%0d busy=%b hold_req=%b, want 0 1 1", qa.size(), busy, hold_req);
                end
            end else begin
                if (ack_cyc < 0) begin
                    hold_ack = (i >= ack_dly);
                    if (hold_ack) ack_cyc = cyc + 1;
                end else begin
                    hold_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (out_valid === 1'b1 && beat == stall_beat && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_valid === 1'b1 && out_ready) begin
                    checks++;
                    if (qa.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got (%0d,%h), want no beat", out_addr, out_data);
                    end else begin
                        if (out_addr !== qa[0] || out_data !== qd[0]) begin
                            errors++;
                            $display("FAIL beat: got (%0d,%h), want (%0d,%h)", out_addr, out_data, qa[0], qd[0]);
                        end
                        void'(qa.pop_front());
                        void'(qd.pop_front());
                    end
                    beat++;
                end
                held = (out_valid === 1'b1) && !out_ready;
                pd = out_data;
                pa = out_addr;
                start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                first = ADDR_W'($urandom);
                last  = ADDR_W'($urandom);
                @(negedge clk);
                i++;
                budget--;
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: no done after 400 cycles, beats_left=%0d, want done", qa.size());
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || hold_req !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dump_end: done=%b busy=%b hold_req=%b out_valid=%b, want 0 0 0 0",
                         done, busy, hold_req, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; first = '0; last = '0; hold_ack = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (hold_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: hold_req=%b out_valid=%b busy=%b done=%b range_err=%b, want all 0",
                     hold_req, out_valid, busy, done, range_err);
        end
        checks++;
        if (out_data !== '0 || out_addr !== '0 || ra !== '0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h out_addr=%0d ra=%0d, want 0 0 0", out_data, out_addr, ra);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int span;
        do_dump(5'd1, 5'd3, 0, -1, 0, 1'b0, span);
        checks++;
        if (span != 6) begin
            errors++;
            $display("FAIL basic_timing: ack-to-done edges=%0d, want 6", span);
        end
    endtask

    task automatic test_single_r0();
        int span;
        do_dump(5'd0, 5'd0, 0, -1, 0, 1'b0, span);
        checks++;
        if (span != 2) begin
            errors++;
            $display("FAIL single_timing: ack-to-done edges=%0d, want 2", span);
        end
    endtask

    task automatic test_stall();
        int span;
        do_dump(5'd1, 5'd3, 1, 1, 3, 1'b0, span);
        checks++;
        if (span != 9) begin
            errors++;
            $display("FAIL stall_timing: ack-to-done edges=%0d, want 9", span);
        end
    endtask

    task automatic test_range_err();
        start = 1'b1; first = 5'd5; last = 5'd4;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (range_err !== 1'b1 || busy !== 1'b0 || hold_req !== 1'b0) begin
            errors++;
            $display("FAIL range_err_pulse: range_err=%b busy=%b hold_req=%b, want 1 0 0", range_err, busy, hold_req);
        end
        @(negedge clk);
        checks++;
        if (range_err !== 1'b0 || busy !== 1'b0 || hold_req !== 1'b0) begin
            errors++;
            $display("FAIL range_err_after: range_err=%b busy=%b hold_req=%b, want 0 0 0", range_err, busy, hold_req);
        end
    endtask

    task automatic test_top_range();
        int span;
        do_dump(5'd30, 5'd31, 2, -1, 0, 1'b0, span);
        checks++;
        if (span != 4) begin
            errors++;
            $display("FAIL top_timing: ack-to-done edges=%0d, want 4", span);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || ra !== 5'd31) begin
                errors++;
                $display("FAIL top_idle: busy=%b out_valid=%b ra=%0d, want 0 0 31", busy, out_valid, ra);
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget = 50;
        int span;
        start = 1'b1; first = 5'd1; last = 5'd3;
        @(negedge clk);
        start = 1'b0; hold_ack = 1'b1;
        @(negedge clk);
        hold_ack = 1'b0; out_ready = 1'b1;
        while (budget > 0 && !(out_valid === 1'b1 && out_addr === 5'd2)) begin
            @(negedge clk);
            budget--;
        end
        out_ready = 1'b0;
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL reset_mid_reach: beat 2 not presented, out_addr=%0d, want 2", out_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || hold_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%b hold_req=%b busy=%b, want 0 0 0", out_valid, hold_req, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
        do_dump(5'd1, 5'd3, 0, -1, 0, 1'b0, span);
        checks++;
        if (span != 6) begin
            errors++;
            $display("FAIL reset_mid_redump: ack-to-done edges=%0d, want 6", span);
        end
    endtask

    task automatic test_random();
        int span;
        int f;
        int l;
        for (int n = 0; n < 20; n++) begin
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            regs[0] = '0;
            f = int'($urandom_range(0, 31));
            l = f + int'($urandom_range(0, 8));
            if (l > 31) l = 31;
            do_dump(ADDR_W'(f), ADDR_W'(l), int'($urandom_range(0, 3)), -1, 0, 1'b1, span);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        regs[0]  = '0;
        regs[1]  = 32'd10;
        regs[2]  = 32'd100;
        regs[3]  = 32'd7;
        regs[30] = 32'h0000_DEAD;
        regs[31] = 32'h0000_BEEF;

        test_reset();
        test_basic();
        test_single_r0();
        test_stall();
        test_range_err();
        test_top_range();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
